dmem_responder: RTL and testbench

Memory-side responder for the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It then performs a byte-enabled access on a word-addressed RAM and returns a response (read data or store acknowledge) over a second valid/ready handshake. It sits between the core's data-memory request port and the backing storage, replacing the zero-latency combinational data memory.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_ram.sv | 43 ++++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e  : responder FSM states
//   WORD_W   : data word width, BE_W : byte enables per word, BYTE_W : bits per byte
//   addr_err : flags a byte address that is misaligned or beyond the RAM
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

  // Word index is compared at full width so no out-of-range address aliases onto a real word.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, DEPTH_WORDS x WORD_W, per-byte write enables, registered read.
//   clk   : clock
//   we    : write strobe, bytes selected by be take wdata
//   re    : read strobe, rdata updates on the next edge and holds otherwise
//   addr  : word index
//   be    : byte enables for writes
//   wdata : write data
//   rdata : registered read data
// Contents have no reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[addr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store port.
// Accepts one request at a time, waits LATENCY cycles, performs one byte-enabled RAM access,
// then holds the response until the consumer takes it.
//   clk, resetb           : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_we, req_addr      : 1 = store / byte address
//   req_be, req_wdata     : store byte enables / store data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : load data, 0 for stores and errors
//   rsp_err               : misaligned or out-of-range request
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AddrW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WaitInit = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] wdata_q;
  logic              rsp_err_q;
  logic              rsp_load_q;  // response carries RAM read data

  logic              acc_err;
  logic              ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] ram_rdata;

  assign acc_err = addr_err(addr_q, DEPTH_WORDS);
  // Reset on the ACCESS edge must not let the store commit.
  assign ram_we  = (state_q == StAccess) && !acc_err && we_q && !resetb;
  assign ram_re  = (state_q == StAccess) && !acc_err && !we_q;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AddrW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q[AddrW+1:2]),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            if (LATENCY == 0) begin
              state_q <= StAccess;
            end else begin
              state_q    <= StWait;
              wait_cnt_q <= WaitInit;
            end
          end
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            state_q <= StAccess;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        StAccess: begin
          rsp_err_q  <= acc_err;
          rsp_load_q <= !acc_err && !we_q;
          state_q    <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  // RAM read register holds its value while in RESP since re is only pulsed in ACCESS.
  assign rsp_rdata = rsp_load_q ? ram_rdata : '0;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        resetb = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Zero-latency instance: shares request fields and rsp_ready, has its own valid/reset.
  logic        z_resetb = 1'b1;
  logic        z_valid = 1'b0;
  logic        z_ready;
  logic        z_rsp_valid;
  logic [31:0] z_rdata;
  logic        z_err;

  int n_checks = 0;
  int n_errs = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk       (clk),
    .resetb    (z_resetb),
    .req_valid (z_valid),
    .req_ready (z_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (z_rdata),
    .rsp_err   (z_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance with rsp_ready high.
  // lat is the edge (relative to the accept edge) at which rsp_valid is first sampled high.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                      output int lat);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    lat = n + 1;
    rdata = rsp_rdata;
    err = rsp_err;
    @(posedge clk); #1;
  endtask

  // Seed addr with 0, start a store of a new value, reset k edges after accept.
  task automatic reset_mid(input string tag, input logic [31:0] addr, input int k,
                           input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b1, addr, 4'hF, 32'h0, rd, er, lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_be = 4'hF; req_wdata = 32'hA5A5_5A5A;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    resetb = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rst_ready"}, 32'(req_ready), 32'd1);
    resetb = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    end
    xact(1'b0, addr, 4'h0, 32'h0, rd, er, lat);
    check({tag, "_readback"}, rd, exp);
    check({tag, "_err"}, 32'(er), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Zero-latency stream table: stores to words 0..3, then loads of the same words.
  logic        s_we [8];
  logic [31:0] s_addr [8];
  logic [31:0] s_wdata [8];
  logic [31:0] s_exp [8];

  task automatic drive_z(input int i);
    req_we = s_we[i]; req_addr = s_addr[i]; req_be = 4'hF; req_wdata = s_wdata[i];
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    resetb = 1'b0;

    // Full store, then readback
    xact(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, rd, er, lat);
    check("st_latency", 32'(lat), 32'd4);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    check("ld_latency", 32'(lat), 32'd4);
    check("ld_rdata", rd, 32'hDEAD_BEEF);
    check("ld_err", 32'(er), 32'd0);

    // Partial store bytes 0 and 2
    xact(1'b1, 32'h10, 4'b0101, 32'h1122_3344, rd, er, lat);
    xact(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    check("partial_rdata", rd, 32'hDE22_BE44);

    // Empty byte enable: acked, nothing changes
    xact(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, rd, er, lat);
    check("be0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    check("be0_rdata", rd, 32'hDE22_BE44);

    // Errors
    xact(1'b1, 32'h0, 4'hF, 32'h0123_4567, rd, er, lat);
    xact(1'b0, 32'h13, 4'h0, 32'h0, rd, er, lat);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_rdata", rd, 32'd0);
    xact(1'b1, 32'h0000_1000, 4'hF, 32'hCAFE_F00D, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xact(1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    check("oor_word0", rd, 32'h0123_4567);
    check("oor_word0_err", 32'(er), 32'd0);

    // Back-pressure with a second request pending
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_addr = 32'h0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDE22_BE44);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_hs_ready", 32'(req_ready), 32'd1);
    check("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_second_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_second_rdata", rsp_rdata, 32'h0123_4567);
    @(posedge clk); #1;

    // Reset during WAIT, ACCESS and RESP of a store
    reset_mid("rst_wait", 32'h20, 0, 32'h0);
    reset_mid("rst_access", 32'h24, 2, 32'h0);
    reset_mid("rst_resp", 32'h28, 3, 32'hA5A5_5A5A);

    // Zero-latency streaming
    for (int i = 0; i < 4; i++) begin
      s_we[i] = 1'b1; s_addr[i] = 32'(i * 4); s_wdata[i] = 32'h1000_0001 * (i + 1);
      s_exp[i] = 32'h0;
      s_we[i+4] = 1'b0; s_addr[i+4] = 32'(i * 4); s_wdata[i+4] = 32'h0;
      s_exp[i+4] = 32'h1000_0001 * (i + 1);
    end
    @(posedge clk); #1;
    z_resetb = 1'b0;
    @(posedge clk); #1;
    begin
      int acc_edge [8];
      int n_acc = 0;
      int n_rsp = 0;
      int last_rsp = 0;
      logic took = 1'b0;
      drive_z(0);
      z_valid = 1'b1;
      for (int e = 0; e < 80 && n_rsp < 8; e++) begin
        if (took) begin
          n_acc++;
          if (n_acc < 8) drive_z(n_acc);
          else z_valid = 1'b0;
        end
        took = z_ready && z_valid;
        if (took) acc_edge[n_acc] = e + 1;
        if (z_rsp_valid) begin
          check("z_rdata", z_rdata, s_exp[n_rsp]);
          check("z_err", 32'(z_err), 32'd0);
          check("z_latency", 32'(e + 1 - acc_edge[n_rsp]), 32'd2);
          if (n_rsp > 0) check("z_period", 32'(e + 1 - last_rsp), 32'd3);
          last_rsp = e + 1;
          n_rsp++;
        end
        @(posedge clk); #1;
      end
      z_valid = 1'b0;
      check("z_rsp_count", 32'(n_rsp), 32'd8);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
